// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe: one-stage ALU with a valid/ready handshake on each side.
// Ports: clk, rst, in_valid/in_ready with in1, in2, fun and set_cc in;
// out_valid/out_ready with result, overflow, carry and cc out.
module alu_cc_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       fun,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry,
  output logic [2:0]       cc
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE =
    {{WIDTH{1'b0}}, 1'b1};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;
  logic [2:0]       cc_q, cc_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_cry;
  logic             accept;

  assign add_w = {1'b0, in1} + {1'b0, in2};
  assign sub_w = {1'b0, in1} + {1'b0, ~in2} + ONE;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_cry = 1'b0;
    unique case (fun)
      2'b00: begin
        alu_res = add_w[MSB:0];
        alu_ovf = (in1[MSB] == in2[MSB]) &&
                  (alu_res[MSB] != in1[MSB]);
        alu_cry = add_w[WIDTH];
      end
      2'b01: begin
        alu_res = sub_w[MSB:0];
        alu_ovf = (in1[MSB] != in2[MSB]) &&
                  (alu_res[MSB] != in1[MSB]);
        // carry out of in1 + ~in2 + 1 means no borrow
        alu_cry = ~sub_w[WIDTH];
      end
      2'b10: alu_res = in1 & in2;
      2'b11: alu_res = in1 ^ in2;
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      ovf_d       = alu_ovf;
      carry_d     = alu_cry;
      if (set_cc) begin
        cc_d = {alu_res == '0, alu_res[MSB], alu_ovf};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      cc_q        <= 3'b000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// tb_alu_cc_pipe: directed plus random stimulus for alu_cc_pipe,
// scoreboard queue of expected results, WIDTH=64.
module tb_alu_cc_pipe;

  typedef struct {
    logic [63:0] res;
    logic        ov;
    logic        ca;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic [1:0]  fun = 2'b00;
  logic        set_cc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        overflow;
  logic        carry;
  logic [2:0]  cc;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  logic [2:0] cc_m = 3'b000;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  alu_cc_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2),
    .fun(fun), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow),
    .carry(carry), .cc(cc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] f,
                                 input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t e;
    logic [64:0] u;
    logic signed [64:0] s;
    e.res = '0;
    e.ov  = 1'b0;
    e.ca  = 1'b0;
    case (f)
      2'b00: begin
        u = {1'b0, a} + {1'b0, b};
        s = $signed({a[63], a}) + $signed({b[63], b});
        e.res = u[63:0];
        e.ov  = s != $signed({e.res[63], e.res});
        e.ca  = u[64];
      end
      2'b01: begin
        s = $signed({a[63], a}) - $signed({b[63], b});
        e.res = a - b;
        e.ov  = s != $signed({e.res[63], e.res});
        e.ca  = a < b;
      end
      2'b10: e.res = a & b;
      default: e.res = a ^ b;
    endcase
    return e;
  endfunction

  // One clock: check at negedge, update model, advance past posedge.
  task automatic step();
    exp_t e;
    logic rdy;
    @(negedge clk);
    rdy = (q.size() == 0) || out_ready;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, rdy);
    chk("cc", cc, cc_m);
    if (q.size() != 0) begin
      chk("result", result, q[0].res);
      chk("overflow", overflow, q[0].ov);
      chk("carry", carry, q[0].ca);
    end
    if (!rst) begin
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
      end
      if (in_valid && rdy) begin
        e = model(fun, in1, in2);
        q.push_back(e);
        if (set_cc) cc_m = {e.res == 0, e.res[63], e.ov};
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      cc_m = 3'b000;
    end
    #1;
  endtask

  task automatic beat(input logic [1:0] f,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic sc);
    in_valid = 1'b1;
    fun = f;
    in1 = a;
    in2 = b;
    set_cc = sc;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic expect_out(input string tag,
                            input logic [63:0] r,
                            input logic ov,
                            input logic ca);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".result"}, result, r);
    chk({tag, ".ovf"}, overflow, ov);
    chk({tag, ".carry"}, carry, ca);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", result, 64'd0);
    chk("rst.ovf", overflow, 1'b0);
    chk("rst.carry", carry, 1'b0);
    chk("rst.cc", cc, 3'b000);
    chk("rst.in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    beat(2'b00, MAXP, MAXP, 1'b1);
    expect_out("add_ovf", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    chk("add_ovf.cc", cc, 3'b011);

    beat(2'b01, 64'd63, 64'd63, 1'b1);
    expect_out("sub_zero", 64'd0, 1'b0, 1'b0);
    chk("sub_zero.cc", cc, 3'b100);
    beat(2'b00, 64'd63, -64'sd63, 1'b0);
    expect_out("add_zero", 64'd0, 1'b0, 1'b1);
    chk("add_zero.cc", cc, 3'b100);

    beat(2'b01, 64'h8000_0000_0000_0001, MAXP, 1'b0);
    expect_out("sub_ovf", 64'd2, 1'b1, 1'b0);
    beat(2'b01, 64'd1, 64'd2, 1'b1);
    expect_out("sub_brw", '1, 1'b0, 1'b1);
    chk("sub_brw.cc", cc, 3'b010);
    idle();

    out_ready = 1'b0;
    beat(2'b00, 64'd10, 64'd20, 1'b0);
    expect_out("bp_a", 64'd30, 1'b0, 1'b0);
    fun = 2'b11;
    in1 = 64'h55;
    in2 = 64'h0F;
    repeat (3) begin
      step();
      chk("bp.in_ready", in_ready, 1'b0);
      expect_out("bp_hold", 64'd30, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    step();
    expect_out("bp_b", 64'h5A, 1'b0, 1'b0);
    idle();
    chk("bp.drained", out_valid, 1'b0);

    beat(2'b10, 64'hF0F0, 64'hFF00, 1'b0);
    expect_out("b2b_and", 64'hF000, 1'b0, 1'b0);
    beat(2'b11, 64'hFF, 64'h0F, 1'b0);
    expect_out("b2b_xor", 64'hF0, 1'b0, 1'b0);
    beat(2'b00, 64'd1, 64'd1, 1'b0);
    expect_out("b2b_add", 64'd2, 1'b0, 1'b0);
    beat(2'b01, 64'd5, 64'd7, 1'b0);
    expect_out("b2b_sub", -64'sd2, 1'b0, 1'b1);
    idle();

    out_ready = 1'b0;
    beat(2'b00, MAXP, MAXP, 1'b1);
    chk("mid.cc", cc, 3'b011);
    rst = 1'b1;
    beat(2'b10, 64'd1, 64'd1, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mid.out_valid", out_valid, 1'b0);
    chk("mid.result", result, 64'd0);
    chk("mid.cc0", cc, 3'b000);
    chk("mid.in_ready", in_ready, 1'b1);
    idle();
    idle();

    for (int i = 0; i < 60; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      fun       = 2'($urandom_range(0, 3));
      set_cc    = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      if (i % 4 == 0) begin
        in1 = 64'($urandom_range(0, 3));
        in2 = 64'($urandom_range(0, 3));
      end else begin
        in1 = {$urandom, $urandom};
        in2 = {$urandom, $urandom};
      end
      step();
    end
    out_ready = 1'b1;
    idle();
    idle();
    chk("drain.empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
